// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between a load/store master and
// the memory responder.
//   master modport: drives read, write, address, in_data; observes responses.
//   slave modport : observes requests; drives out_addr, out_data, valid, ready.
// When MEM_RESPONDER_RANGE_CHECK_EN is defined the bundle also carries the
// response-side error flag.
interface mem_responder_if #(
    parameter int ADDRESS_BITS = 20,
    parameter int DATA_WIDTH   = 32
);
    logic                    read;
    logic                    write;
    logic [ADDRESS_BITS-1:0] address;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [ADDRESS_BITS-1:0] out_addr;
    logic [DATA_WIDTH-1:0]   out_data;
    logic                    valid;
    logic                    ready;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    logic                    error;
`endif

    modport master (
        output read, write, address, in_data,
        input  out_addr, out_data, valid, ready
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        , input error
`endif
    );

    modport slave (
        input  read, write, address, in_data,
        output out_addr, out_data, valid, ready
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        , output error
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-addressed on-chip RAM that answers each accepted
// load/store request with a one-cycle valid pulse LATENCY cycles later.
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : mem_responder_if.slave (read/write/address/in_data in,
//           out_addr/out_data/valid/ready out, plus error when enabled)
// Optional: define MEM_RESPONDER_RANGE_CHECK_EN to flag requests whose
// address has bits set at or above DEPTH_BITS (error=1, out_data=0, no write).
//
// state | meaning
// IDLE  | ready=1, waiting for read|write
// BUSY  | request captured, counting down the remaining latency
// RESP  | valid=1 for one cycle with the response
module mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int DEPTH_BITS   = 8,
    parameter int LATENCY      = 2
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // BUSY spends LATENCY-1 cycles; the counter reaches 0 on the last one.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                  state;
    state_t                  state_next;
    logic [3:0]              counter;
    logic [ADDRESS_BITS-1:0] cap_addr;
    logic [DATA_WIDTH-1:0]   cap_data;
    logic                    cap_wr;
    logic [ADDRESS_BITS-1:0] resp_addr;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_wr;
    logic [DEPTH_BITS-1:0]   index;
    logic                    accept;
    logic                    go_resp;
    logic                    out_of_range;
    logic                    commit_wr;

    logic [DATA_WIDTH-1:0]   mem [2**DEPTH_BITS];

    assign bus.ready = reset && (state == IDLE);
    assign accept    = bus.ready && (bus.read || bus.write);

    // With LATENCY=1 the response is produced on the accepting edge, so the
    // live request is used instead of the (not yet loaded) capture registers.
    always_comb begin
        resp_addr = cap_addr;
        resp_data = cap_data;
        resp_wr   = cap_wr;
        if (state == IDLE) begin
            resp_addr = bus.address;
            resp_data = bus.in_data;
            resp_wr   = bus.write;
        end
    end

    assign index = resp_addr[DEPTH_BITS-1:0];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    assign out_of_range = |resp_addr[ADDRESS_BITS-1:DEPTH_BITS];
`else
    assign out_of_range = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go_resp    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        go_resp    = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (counter == 4'd0) begin
                    state_next = RESP;
                    go_resp    = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A reset on the committing edge drops the write.
    assign commit_wr = reset && go_resp && resp_wr && !out_of_range;

    always_ff @(posedge clock) begin
        if (!reset) begin
            counter      <= 4'd0;
            cap_addr     <= '0;
            cap_data     <= '0;
            cap_wr       <= 1'b0;
            bus.valid    <= 1'b0;
            bus.out_addr <= '0;
            bus.out_data <= '0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            bus.error    <= 1'b0;
`endif
        end else begin
            bus.valid <= go_resp;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
            bus.error <= go_resp && out_of_range;
`endif
            if (accept) begin
                cap_addr <= bus.address;
                cap_data <= bus.in_data;
                cap_wr   <= bus.write;
                counter  <= CNT_INIT;
            end else if ((state == BUSY) && (counter != 4'd0)) begin
                counter <= counter - 4'd1;
            end
            if (go_resp) begin
                bus.out_addr <= resp_addr;
                if (out_of_range) begin
                    bus.out_data <= '0;
                end else if (resp_wr) begin
                    bus.out_data <= resp_data;
                end else begin
                    bus.out_data <= mem[index];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (commit_wr) begin
            mem[index] <= resp_data;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int DW = 32;
    localparam int AB = 20;
    localparam int DB = 8;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst1, rst2, rst4;

    mem_responder_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) b1();
    mem_responder_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) b2();
    mem_responder_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW)) b4();

    mem_responder #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .DEPTH_BITS(DB), .LATENCY(1))
        u_dut_l1 (.clock(clock), .reset(rst1), .bus(b1));
    mem_responder #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .DEPTH_BITS(DB), .LATENCY(2))
        u_dut_l2 (.clock(clock), .reset(rst2), .bus(b2));
    mem_responder #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .DEPTH_BITS(DB), .LATENCY(4))
        u_dut_l4 (.clock(clock), .reset(rst4), .bus(b4));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input string what,
                         input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s actual=%h expected=%h", nm, what, act, exp);
        end
    endtask

    task automatic drive(input int sel, input bit rd, input bit wr,
                         input logic [AB-1:0] a, input logic [DW-1:0] d);
        case (sel)
            1: begin b1.read = rd; b1.write = wr; b1.address = a; b1.in_data = d; end
            2: begin b2.read = rd; b2.write = wr; b2.address = a; b2.in_data = d; end
            default: begin b4.read = rd; b4.write = wr; b4.address = a; b4.in_data = d; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 1) ? b1.ready : (sel == 2) ? b2.ready : b4.ready;
    endfunction
    function automatic logic get_valid(input int sel);
        return (sel == 1) ? b1.valid : (sel == 2) ? b2.valid : b4.valid;
    endfunction
    function automatic logic [DW-1:0] get_data(input int sel);
        return (sel == 1) ? b1.out_data : (sel == 2) ? b2.out_data : b4.out_data;
    endfunction
    function automatic logic [AB-1:0] get_addr(input int sel);
        return (sel == 1) ? b1.out_addr : (sel == 2) ? b2.out_addr : b4.out_addr;
    endfunction
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    function automatic logic get_err(input int sel);
        return (sel == 1) ? b1.error : (sel == 2) ? b2.error : b4.error;
    endfunction
`endif

    // Reference model of the RAM behind the LATENCY=2 instance.
    logic [DW-1:0] mdl [256];

    task automatic model_step(input bit rd, input bit wr, input logic [AB-1:0] a,
                              input logic [DW-1:0] d,
                              output logic [DW-1:0] ed, output bit ee);
        int idx;
        bit oor;
        idx = int'(a) % (1 << DB);
        oor = 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        oor = (int'(a) >> DB) != 0;
`endif
        ee = oor;
        if (oor) begin
            ed = '0;
        end else if (wr) begin
            mdl[idx] = d;
            ed = d;
        end else begin
            ed = (rd) ? mdl[idx] : mdl[idx];
        end
    endtask

    // One complete request/response exchange, sampled on falling edges.
    task automatic txn(input int sel, input int lat, input bit rd, input bit wr,
                       input logic [AB-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] exp_d, input bit exp_e, input string nm);
        int n;
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(nm, "ready_before", {31'd0, get_ready(sel)}, 32'd1);
        drive(sel, rd, wr, a, d);
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, '0, '0);
        n = 1;
        while (get_valid(sel) !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(nm, "latency", 32'(n), 32'(lat));
        check(nm, "out_addr", {12'd0, get_addr(sel)}, {12'd0, a});
        check(nm, "out_data", get_data(sel), exp_d);
        check(nm, "ready_in_resp", {31'd0, get_ready(sel)}, 32'd0);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        check(nm, "error", {31'd0, get_err(sel)}, {31'd0, exp_e});
`else
        if (exp_e) check(nm, "model_error", 32'd1, 32'd0);
`endif
        @(negedge clock);
        check(nm, "valid_after", {31'd0, get_valid(sel)}, 32'd0);
        check(nm, "ready_after", {31'd0, get_ready(sel)}, 32'd1);
    endtask

    typedef struct {
        bit            rd;
        bit            wr;
        logic [AB-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] exp_d;
        bit            exp_e;
        string         nm;
    } vec_t;

    vec_t tbl [8];

    task automatic set_vec(input int i, input bit rd, input bit wr, input logic [AB-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] ed,
                           input bit ee, input string nm);
        tbl[i].rd = rd; tbl[i].wr = wr; tbl[i].addr = a; tbl[i].data = d;
        tbl[i].exp_d = ed; tbl[i].exp_e = ee; tbl[i].nm = nm;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] ed;
        bit ee;
        int n;

        set_vec(0, 1'b0, 1'b1, 20'h00010, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, "wr_10");
        set_vec(1, 1'b1, 1'b0, 20'h00010, 32'h0,        32'hDEADBEEF, 1'b0, "rd_10");
        set_vec(2, 1'b1, 1'b1, 20'h00020, 32'h12345678, 32'h12345678, 1'b0, "rdwr_20");
        set_vec(3, 1'b1, 1'b0, 20'h00020, 32'h0,        32'h12345678, 1'b0, "rd_20");
        set_vec(4, 1'b0, 1'b1, 20'h00005, 32'h00000011, 32'h00000011, 1'b0, "wr_05");
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
        set_vec(5, 1'b0, 1'b1, 20'h00105, 32'h000000AA, 32'h0,        1'b1, "wr_105");
        set_vec(6, 1'b1, 1'b0, 20'h00005, 32'h0,        32'h00000011, 1'b0, "rd_05");
        set_vec(7, 1'b1, 1'b0, 20'h00105, 32'h0,        32'h0,        1'b1, "rd_105");
`else
        set_vec(5, 1'b0, 1'b1, 20'h00105, 32'h000000AA, 32'h000000AA, 1'b0, "wr_105");
        set_vec(6, 1'b1, 1'b0, 20'h00005, 32'h0,        32'h000000AA, 1'b0, "rd_05");
        set_vec(7, 1'b1, 1'b0, 20'h00105, 32'h0,        32'h000000AA, 1'b0, "rd_105");
`endif

        // Reset held with a read request pending on every instance.
        rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
        drive(1, 1'b1, 1'b0, 20'h00010, '0);
        drive(2, 1'b1, 1'b0, 20'h00010, '0);
        drive(4, 1'b1, 1'b0, 20'h00010, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("reset", "valid", {31'd0, b2.valid}, 32'd0);
            check("reset", "ready", {31'd0, b2.ready}, 32'd0);
            check("reset", "out_data", b2.out_data, 32'd0);
            check("reset", "out_addr", {12'd0, b2.out_addr}, 32'd0);
        end
        check("reset_l1", "ready", {31'd0, b1.ready}, 32'd0);
        check("reset_l4", "ready", {31'd0, b4.ready}, 32'd0);
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        drive(4, 1'b0, 1'b0, '0, '0);
        rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
        @(negedge clock);
        check("release", "ready", {31'd0, b2.ready}, 32'd1);
        check("release", "valid", {31'd0, b2.valid}, 32'd0);

        // Fill the LATENCY=2 RAM so every later read has a defined answer.
        for (int i = 0; i < 256; i++) begin
            model_step(1'b0, 1'b1, 20'(i), 32'hC0DE0000 | 32'(i), ed, ee);
            txn(2, 2, 1'b0, 1'b1, 20'(i), 32'hC0DE0000 | 32'(i), ed, ee, "preload");
        end

        for (int i = 0; i < 8; i++) begin
            model_step(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data, ed, ee);
            txn(2, 2, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data,
                tbl[i].exp_d, tbl[i].exp_e, tbl[i].nm);
        end

        for (int i = 0; i < 300; i++) begin
            int op;
            logic [AB-1:0] a;
            logic [DW-1:0] d;
            op = int'($urandom_range(0, 2));
            a = 20'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a[AB-1:DB] = 12'($urandom_range(1, 4095));
            d = $urandom;
            model_step(op != 1, op != 0, a, d, ed, ee);
            txn(2, 2, op != 1, op != 0, a, d, ed, ee, "random");
        end

        // LATENCY=1 back-to-back write then read.
        n = 0;
        while (b1.ready !== 1'b1 && n < 40) begin @(negedge clock); n++; end
        drive(1, 1'b0, 1'b1, 20'h00005, 32'h1);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("l1_wr", "valid", {31'd0, b1.valid}, 32'd1);
        check("l1_wr", "ready", {31'd0, b1.ready}, 32'd0);
        check("l1_wr", "out_data", b1.out_data, 32'h1);
        check("l1_wr", "out_addr", {12'd0, b1.out_addr}, 32'h5);
        @(negedge clock);
        check("l1_gap", "valid", {31'd0, b1.valid}, 32'd0);
        check("l1_gap", "ready", {31'd0, b1.ready}, 32'd1);
        drive(1, 1'b1, 1'b0, 20'h00005, '0);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, '0, '0);
        check("l1_rd", "valid", {31'd0, b1.valid}, 32'd1);
        check("l1_rd", "ready", {31'd0, b1.ready}, 32'd0);
        check("l1_rd", "out_data", b1.out_data, 32'h1);
        @(negedge clock);
        check("l1_end", "valid", {31'd0, b1.valid}, 32'd0);

        // LATENCY=4 reset while BUSY drops the pending write.
        txn(4, 4, 1'b0, 1'b1, 20'h00030, 32'h11, 32'h11, 1'b0, "l4_prior");
        drive(4, 1'b0, 1'b1, 20'h00030, 32'h77);
        @(negedge clock);
        drive(4, 1'b0, 1'b0, '0, '0);
        check("l4_busy", "ready", {31'd0, b4.ready}, 32'd0);
        @(negedge clock);
        rst4 = 1'b0;
        @(negedge clock);
        rst4 = 1'b1;
        check("l4_rst", "valid", {31'd0, b4.valid}, 32'd0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (b4.valid !== 1'b0) n++;
        end
        check("l4_rst", "stray_valids", 32'(n), 32'd0);
        txn(4, 4, 1'b1, 1'b0, 20'h00030, '0, 32'h11, 1'b0, "l4_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's load/store request interface (read, write, address, in_data -> out_addr, out_data, valid, ready).
- Sits behind the data-memory interface in the single-cycle core's testbench/SoC.
- Provides a word-addressed on-chip RAM that answers each accepted request after a fixed, parameterised latency.
- Protocol: one-deep request capture, busy countdown, one-cycle response pulse.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDRESS_BITS, 20, width of request address.
- DEPTH_BITS, 8, log2 of RAM word count; index = address[DEPTH_BITS-1:0].
- LATENCY, 2, cycles from acceptance to valid. Legal range 1..15.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- read  input  1  read request, sampled only when ready=1.
- write  input  1  write request, sampled only when ready=1.
- address  input  ADDRESS_BITS  request address.
- in_data  input  DATA_WIDTH  write data.
- out_addr  output  ADDRESS_BITS  address of the request being answered.
- out_data  output  DATA_WIDTH  read data, or the written data for write acks.
- valid  output  1  one-cycle response strobe.
- ready  output  1  responder can accept a request this cycle.

Behaviour:
- States: IDLE, BUSY, RESP. State, counter and outputs are registered; ready is decoded from state.
- Reset (reset=0 at a clock edge):
  - state=IDLE, counter=0, valid=0, out_addr=0, out_data=0.
  - ready is forced 0 while reset=0.
  - RAM contents are not reset.
- Reset mid-operation (BUSY or RESP): the pending request is discarded, no valid is issued, and a pending write that has not committed is dropped.
- IDLE:
  - ready=1.
  - Acceptance happens on any edge where read|write=1. Capture address, in_data and the op.
  - Next state: if LATENCY=1 go to RESP; otherwise go to BUSY with counter=LATENCY-2.
- BUSY:
  - ready=0.
  - Counter decrements each cycle. When it is 0, go to RESP.
  - Inputs are ignored.
- RESP:
  - valid=1 for exactly one cycle, ready=0.
  - out_addr = captured address.
  - Next state: IDLE.
- Latency and throughput:
  - Request accepted at edge N produces valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - ready returns the cycle after valid.
  - Maximum throughput is one request per LATENCY+1 cycles.
- Read response: out_data = RAM[index] as read at the RESP transition.
- Write:
  - RAM[index] <= captured in_data on the edge entering RESP.
  - The response is also a valid pulse, with out_data = captured in_data.
- read=1 and write=1 together: treated as a write; no separate read response.
- Outside valid: out_data and out_addr hold their last values; valid=0.
- Address wrap: upper address bits above DEPTH_BITS are ignored, so index aliasing wraps modulo 2^DEPTH_BITS.
- Read-after-write to the same index in back-to-back requests returns the new data.

Optional Feature:
- Macro: MEM_RESPONDER_RANGE_CHECK_EN.
- Defined:
  - Adds output port error (1 bit), driven 0 at reset.
  - If any captured address bit at position DEPTH_BITS or above is 1, the response still pulses valid, with error=1 and out_data=0.
  - An out-of-range write does not modify the RAM.
  - error is valid only when valid=1, and is 0 otherwise.
- Undefined: no error port; addresses alias as described above.

Test Plan:
- Reset: hold reset=0 for 3 cycles with read=1 -> valid=0, ready=0, out_data=0. First cycle after release: ready=1.
- Write then read, LATENCY=2:
  - Write address 0x00010, data 0xDEADBEEF -> valid=1 exactly 2 cycles after acceptance, out_addr=0x00010, out_data=0xDEADBEEF.
  - Read 0x00010 -> out_data=0xDEADBEEF.
- LATENCY=1 back-to-back: write 0x5 with data 0x1 at edge 0 -> valid at cycle 1, ready=1 at cycle 2. Read 0x5 accepted at cycle 2 returns 0x1 at cycle 3. ready=0 in cycles 1 and 3.
- Simultaneous read and write to 0x20 with data 0x12345678 -> single valid pulse, out_data=0x12345678. A later read of 0x20 returns 0x12345678.
- Alias / range check:
  - Write 0x00105 (DEPTH_BITS=8) with data 0xAA, then read 0x00005 -> 0xAA without the macro.
  - With MEM_RESPONDER_RANGE_CHECK_EN: error=1 and out_data=0 on the write response, and the RAM at index 0x05 is unchanged.
- Mid-operation reset, LATENCY=4: accept write 0x30 with data 0x77, assert reset=0 at cycle 2 for one cycle -> no valid pulse. A later read of 0x30 returns the prior contents, not 0x77.
